// File: rtl/psa_loader_if.sv
// Byte streams, BRAM write port and search-engine control bundle for psa_loader.
// master = the loader; slave = host link, BRAMs and search engine.
interface psa_loader_if;
  localparam int unsigned BYTE_W = 8;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  logic              mem_we;
  logic              mem_sel;
  logic [BYTE_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_din;

  logic [BYTE_W-1:0] srch_p;
  logic [BYTE_W-1:0] srch_pl;
  logic [BYTE_W-1:0] srch_b;
  logic [BYTE_W-1:0] srch_bl;
  logic              srch_reset;
  logic              srch_activate;
  logic              srch_done;
  logic [BYTE_W-1:0] srch_found;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  rx_data, rx_valid, srch_done, srch_found, tx_ready,
    output rx_ready, mem_we, mem_sel, mem_addr, mem_din,
           srch_p, srch_pl, srch_b, srch_bl, srch_reset, srch_activate,
           tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, srch_done, srch_found, tx_ready,
    input  rx_ready, mem_we, mem_sel, mem_addr, mem_din,
           srch_p, srch_pl, srch_b, srch_bl, srch_reset, srch_activate,
           tx_data, tx_valid
  );
endinterface

// File: rtl/psa_loader.sv
// Host command front end for the pattern search accelerator: parses a byte
// stream into BRAM writes and search launches, and returns result/status bytes.
module psa_loader #(
  parameter logic [7:0] ACK_BASE = 8'hA0,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  psa_loader_if.master  bus,
  output logic          busy,
  output logic          err
);
  localparam int unsigned BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_LEN, W_DATA,
    S_P, S_PL, S_B, S_BL, S_RST, S_RUN,
    TX_FOUND, TX_ACK, TX_ERR
  } state_t;

  state_t state_q, state_d;
  byte_t  wr_addr_q, wr_addr_d;
  byte_t  rem_q, rem_d;
  byte_t  ack_q, ack_d;
  byte_t  p_q, p_d, pl_q, pl_d, b_q, b_d;

  logic   rx_ready_q, rx_ready_d;
  logic   mem_we_q, mem_we_d;
  logic   mem_sel_q, mem_sel_d;
  byte_t  mem_addr_q, mem_addr_d;
  byte_t  mem_din_q, mem_din_d;
  byte_t  srch_p_q, srch_p_d, srch_pl_q, srch_pl_d;
  byte_t  srch_b_q, srch_b_d, srch_bl_q, srch_bl_d;
  logic   srch_reset_q, srch_reset_d;
  logic   srch_activate_q, srch_activate_d;
  byte_t  tx_data_q, tx_data_d;
  logic   tx_valid_q, tx_valid_d;
  logic   busy_q, busy_d;
  logic   err_q, err_d;

  logic   rx_xfer;
  logic   tx_xfer;

  assign rx_xfer = bus.rx_valid && rx_ready_q;
  assign tx_xfer = tx_valid_q && bus.tx_ready;

  // State register and all registered outputs
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wr_addr_q       <= '0;
      rem_q           <= '0;
      ack_q           <= '0;
      p_q             <= '0;
      pl_q            <= '0;
      b_q             <= '0;
      rx_ready_q      <= 1'b1;
      mem_we_q        <= 1'b0;
      mem_sel_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_din_q       <= '0;
      srch_p_q        <= '0;
      srch_pl_q       <= '0;
      srch_b_q        <= '0;
      srch_bl_q       <= '0;
      srch_reset_q    <= 1'b0;
      srch_activate_q <= 1'b0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_addr_q       <= wr_addr_d;
      rem_q           <= rem_d;
      ack_q           <= ack_d;
      p_q             <= p_d;
      pl_q            <= pl_d;
      b_q             <= b_d;
      rx_ready_q      <= rx_ready_d;
      mem_we_q        <= mem_we_d;
      mem_sel_q       <= mem_sel_d;
      mem_addr_q      <= mem_addr_d;
      mem_din_q       <= mem_din_d;
      srch_p_q        <= srch_p_d;
      srch_pl_q       <= srch_pl_d;
      srch_b_q        <= srch_b_d;
      srch_bl_q       <= srch_bl_d;
      srch_reset_q    <= srch_reset_d;
      srch_activate_q <= srch_activate_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rem_d      = rem_q;
    ack_d      = ack_q;
    p_d        = p_q;
    pl_d       = pl_q;
    b_d        = b_q;
    mem_we_d   = 1'b0;
    mem_sel_d  = mem_sel_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    srch_p_d   = srch_p_q;
    srch_pl_d  = srch_pl_q;
    srch_b_d   = srch_b_q;
    srch_bl_d  = srch_bl_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q;

    case (state_q)
      IDLE: if (rx_xfer) begin
        case (bus.rx_data)
          8'h01: begin
            mem_sel_d = 1'b0;
            ack_d     = ACK_BASE | 8'h01;
            state_d   = W_ADDR;
          end
          8'h02: begin
            mem_sel_d = 1'b1;
            ack_d     = ACK_BASE | 8'h02;
            state_d   = W_ADDR;
          end
          8'h03: begin
            ack_d   = ACK_BASE | 8'h03;
            state_d = S_P;
          end
          default: begin
            err_d     = 1'b1;
            tx_data_d = ERR_BYTE;
            state_d   = TX_ERR;
          end
        endcase
      end
      W_ADDR: if (rx_xfer) begin
        wr_addr_d = bus.rx_data;
        state_d   = W_LEN;
      end
      W_LEN: if (rx_xfer) begin
        rem_d = bus.rx_data;
        if (bus.rx_data == 8'd0) begin
          tx_data_d = ack_q;
          state_d   = TX_ACK;
        end else begin
          state_d = W_DATA;
        end
      end
      // Address wraps mod 256 naturally through the 8-bit adder
      W_DATA: if (rx_xfer) begin
        mem_we_d   = 1'b1;
        mem_addr_d = wr_addr_q;
        mem_din_d  = bus.rx_data;
        wr_addr_d  = wr_addr_q + 8'd1;
        rem_d      = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          tx_data_d = ack_q;
          state_d   = TX_ACK;
        end
      end
      S_P: if (rx_xfer) begin
        p_d     = bus.rx_data;
        state_d = S_PL;
      end
      S_PL: if (rx_xfer) begin
        pl_d    = bus.rx_data;
        state_d = S_B;
      end
      S_B: if (rx_xfer) begin
        b_d     = bus.rx_data;
        state_d = S_BL;
      end
      // Engine computes pl-1, so a zero pattern length is never launched
      S_BL: if (rx_xfer) begin
        if (pl_q == 8'd0) begin
          err_d     = 1'b1;
          tx_data_d = ERR_BYTE;
          state_d   = TX_ERR;
        end else begin
          srch_p_d  = p_q;
          srch_pl_d = pl_q;
          srch_b_d  = b_q;
          srch_bl_d = bus.rx_data;
          state_d   = S_RST;
        end
      end
      S_RST: state_d = S_RUN;
      S_RUN: if (bus.srch_done) begin
        tx_data_d = bus.srch_found;
        state_d   = TX_FOUND;
      end
      TX_FOUND: if (tx_xfer) begin
        tx_data_d = ack_q;
        state_d   = TX_ACK;
      end
      TX_ACK: if (tx_xfer) state_d = IDLE;
      TX_ERR: if (tx_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rx_ready_d      = (state_d inside {IDLE, W_ADDR, W_LEN, W_DATA,
                                       S_P, S_PL, S_B, S_BL});
    tx_valid_d      = (state_d inside {TX_FOUND, TX_ACK, TX_ERR});
    srch_reset_d    = (state_d == S_RST);
    srch_activate_d = (state_d == S_RUN);
    busy_d          = (state_d != IDLE);
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_sel       = mem_sel_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_din       = mem_din_q;
  assign bus.srch_p        = srch_p_q;
  assign bus.srch_pl       = srch_pl_q;
  assign bus.srch_b        = srch_b_q;
  assign bus.srch_bl       = srch_bl_q;
  assign bus.srch_reset    = srch_reset_q;
  assign bus.srch_activate = srch_activate_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_valid      = tx_valid_q;
  assign busy              = busy_q;
  assign err               = err_q;
endmodule

// File: tb/tb_psa_loader.sv
// Scoreboard bench for psa_loader: directed frames, stub search engine,
// negedge monitor comparing tx bytes and BRAM writes against expected queues.
module tb_psa_loader;
  logic CLK100MHZ = 1'b0;
  logic reset;
  logic busy, err;

  psa_loader_if bus();

  psa_loader #(.ACK_BASE(8'hA0), .ERR_BYTE(8'hEE)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .err       (err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  exp_tx[$];
  logic [16:0] exp_wr[$];   // {sel, addr, din}

  int cyc = 0, we_cnt = 0, we_first = -1, we_last = -1;
  int rst_cnt = 0, act_cnt = 0, rst_cyc = 0, act_first = 0;
  logic prev_act = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_td = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Stub engine: done 10 cycles into activate, fixed result 0x12
  logic [3:0] run_cnt;
  assign bus.srch_found = 8'h12;
  always @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      run_cnt       <= 4'd0;
      bus.srch_done <= 1'b0;
    end else if (!bus.srch_activate) begin
      run_cnt       <= 4'd0;
      bus.srch_done <= 1'b0;
    end else begin
      run_cnt <= 4'(run_cnt + 4'd1);
      if (run_cnt == 4'd9) bus.srch_done <= 1'b1;
    end
  end

  // Monitor: output transfers are popped from the scoreboard queues
  always @(negedge CLK100MHZ) begin
    cyc++;
    if (prev_hold && bus.tx_valid) check("tx_hold", bus.tx_data, prev_td);
    if (bus.tx_valid && bus.tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tx_unexpected: got %0h want none", bus.tx_data);
      end else check("tx_byte", bus.tx_data, exp_tx.pop_front());
    end
    if (bus.mem_we) begin
      we_cnt++;
      if (we_first < 0) we_first = cyc;
      we_last = cyc;
      if (exp_wr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_unexpected: got %0h want none",
                 {bus.mem_sel, bus.mem_addr, bus.mem_din});
      end else check("mem_write", {bus.mem_sel, bus.mem_addr, bus.mem_din}, exp_wr.pop_front());
    end
    if (bus.srch_reset) begin
      rst_cnt++;
      rst_cyc = cyc;
      check("act_low_in_reset", bus.srch_activate, 1'b0);
    end
    if (bus.srch_activate) begin
      act_cnt++;
      if (!prev_act) act_first = cyc;
    end
    prev_act  = bus.srch_activate;
    prev_hold = bus.tx_valid && !bus.tx_ready;
    prev_td   = bus.tx_data;
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge CLK100MHZ);
    while (!bus.rx_ready && n < 200) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_timeout: got rx_ready=0 want 1 for byte %0h", b);
    end
    @(posedge CLK100MHZ); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge CLK100MHZ);
    while (busy && n < 500) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (n >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got busy=1 want 0", name);
    end
    @(posedge CLK100MHZ); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, abase, n;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    reset        = 1'b1;
    idle(2);
    check("rst_rx_ready", bus.rx_ready, 1'b1);
    check("rst_outputs", {bus.mem_we, bus.mem_sel, bus.tx_valid, busy, err,
                          bus.srch_reset, bus.srch_activate}, 7'd0);
    check("rst_bytes", {bus.mem_addr, bus.mem_din, bus.tx_data, bus.srch_pl}, 32'd0);
    reset = 1'b0;
    idle(2);

    // WRITE_DATA with wrap-around, back-to-back payload
    exp_wr.push_back({1'b0, 8'hFE, 8'h11});
    exp_wr.push_back({1'b0, 8'hFF, 8'h22});
    exp_wr.push_back({1'b0, 8'h00, 8'h33});
    exp_tx.push_back(8'hA1);
    base = we_cnt; we_first = -1;
    send(8'h01); send(8'hFE); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    wait_idle("wd");
    check("wd_count", we_cnt - base, 3);
    check("wd_consecutive", we_last - we_first, 2);
    check("wd_ack_done", exp_tx.size(), 0);

    // WRITE_PAT with a gap in rx_valid, then a zero-length frame
    exp_wr.push_back({1'b1, 8'h10, 8'hAA});
    exp_wr.push_back({1'b1, 8'h11, 8'hBB});
    exp_tx.push_back(8'hA2);
    send(8'h02); send(8'h10); send(8'h02); send(8'hAA);
    idle(3);
    send(8'hBB);
    wait_idle("wp");
    exp_tx.push_back(8'hA2);
    base = we_cnt;
    send(8'h02); send(8'h05); send(8'h00);
    wait_idle("wp0");
    check("wp0_no_write", we_cnt - base, 0);

    // SEARCH with tx_ready held low for 5 cycles
    bus.tx_ready = 1'b0;
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'hA3);
    rbase = rst_cnt; abase = act_cnt;
    send(8'h03); send(8'h00); send(8'h04); send(8'h20); send(8'h40);
    n = 0;
    @(negedge CLK100MHZ);
    while (!bus.tx_valid && n < 100) begin
      @(negedge CLK100MHZ);
      n++;
    end
    check("srch_tx_valid", bus.tx_valid, 1'b1);
    check("srch_args", {bus.srch_p, bus.srch_pl, bus.srch_b, bus.srch_bl}, 32'h00042040);
    check("srch_reset_pulses", rst_cnt - rbase, 1);
    check("srch_act_cycles", act_cnt - abase, 11);
    check("srch_act_after_reset", act_first - rst_cyc, 1);
    check("srch_act_dropped", bus.srch_activate, 1'b0);
    check("srch_found_data", bus.tx_data, 8'h12);
    repeat (5) begin
      @(negedge CLK100MHZ);
      check("srch_tx_valid_held", bus.tx_valid, 1'b1);
    end
    @(posedge CLK100MHZ); #1;
    bus.tx_ready = 1'b1;
    wait_idle("srch");

    // Unknown command, then a valid frame; err stays sticky
    exp_tx.push_back(8'hEE);
    exp_tx.push_back(8'hA1);
    send(8'h7F);
    check("err_set", err, 1'b1);
    send(8'h01); send(8'h00); send(8'h00);
    wait_idle("bad_cmd");
    check("err_sticky", err, 1'b1);

    // SEARCH with pl=0 is rejected without launching
    exp_tx.push_back(8'hEE);
    rbase = rst_cnt; abase = act_cnt;
    send(8'h03); send(8'h00); send(8'h00); send(8'h00); send(8'h10);
    wait_idle("pl0");
    check("pl0_no_reset", rst_cnt - rbase, 0);
    check("pl0_no_activate", act_cnt - abase, 0);
    check("pl0_args_held", {bus.srch_p, bus.srch_pl, bus.srch_b, bus.srch_bl}, 32'h00042040);

    // Reset during W_DATA after one of three payload bytes
    exp_wr.push_back({1'b0, 8'h30, 8'hAA});
    send(8'h01); send(8'h30); send(8'h03); send(8'hAA);
    @(negedge CLK100MHZ); #1;
    reset = 1'b1;
    #1;
    check("rstw_rx_ready", bus.rx_ready, 1'b1);
    check("rstw_outputs", {bus.mem_we, bus.tx_valid, busy, err, bus.mem_sel}, 5'd0);
    check("rstw_addr", {bus.mem_addr, bus.mem_din}, 16'd0);
    idle(2);
    reset = 1'b0;
    idle(10);
    check("rstw_no_tail", exp_tx.size() + exp_wr.size(), 0);

    // Reset during S_RUN
    send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    n = 0;
    @(negedge CLK100MHZ);
    while (!bus.srch_activate && n < 100) begin
      @(negedge CLK100MHZ);
      n++;
    end
    check("rsts_running", bus.srch_activate, 1'b1);
    idle(3);
    reset = 1'b1;
    #1;
    check("rsts_activate", bus.srch_activate, 1'b0);
    check("rsts_args", {bus.srch_p, bus.srch_pl, bus.srch_b, bus.srch_bl}, 32'd0);
    check("rsts_state", {busy, err, bus.tx_valid, bus.rx_ready}, 4'b0001);
    idle(2);
    reset = 1'b0;
    idle(15);

    // Normal frame after reset
    exp_wr.push_back({1'b0, 8'h00, 8'h5A});
    exp_tx.push_back(8'hA1);
    send(8'h01); send(8'h00); send(8'h01); send(8'h5A);
    wait_idle("post_rst");
    check("post_rst_err", err, 1'b0);
    check("queues_empty", exp_tx.size() + exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
